// File: rtl/eeprom_arbiter.sv
// rtl/eeprom_arbiter.sv - two-requester round-robin arbiter in front of a strobe/ready EEPROM reader
module eeprom_arbiter #(
    parameter int STROBE_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_a,
    input  logic [10:0] addr_a,
    input  logic        req_b,
    input  logic [10:0] addr_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        eep_strobe,
    output logic [10:0] eep_address,
    input  logic        eep_ready,
    input  logic [7:0]  eep_data
);

    localparam int CW = (STROBE_TIMEOUT < 1) ? 1 : $clog2(STROBE_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STROBE_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT_DONE,
        RESPOND
    } state_t;

    state_t        state, state_nx;
    logic          rdy_m, rdy_s;
    logic [CW-1:0] cnt, cnt_nx;
    logic          grant_b, grant_nx;
    logic          last_b, last_nx;
    logic          strobe_nx, ack_a_nx, ack_b_nx, err_nx;
    logic [10:0]   addr_nx;
    logic [7:0]    rdata_nx;
    logic          win_b;

    // eep_ready comes from the divided reader clock, so it is only used after two flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_m <= 1'b0;
            rdy_s <= 1'b0;
        end else begin
            rdy_m <= eep_ready;
            rdy_s <= rdy_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            grant_b     <= 1'b0;
            last_b      <= 1'b1;
            eep_strobe  <= 1'b0;
            eep_address <= '0;
            ack_a       <= 1'b0;
            ack_b       <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            grant_b     <= grant_nx;
            last_b      <= last_nx;
            eep_strobe  <= strobe_nx;
            eep_address <= addr_nx;
            ack_a       <= ack_a_nx;
            ack_b       <= ack_b_nx;
            err         <= err_nx;
            rdata       <= rdata_nx;
        end
    end

    // B wins when alone, or when both ask and A was served last
    assign win_b = req_b && (!req_a || !last_b);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        grant_nx  = grant_b;
        last_nx   = last_b;
        strobe_nx = eep_strobe;
        addr_nx   = eep_address;
        ack_a_nx  = 1'b0;
        ack_b_nx  = 1'b0;
        err_nx    = err;
        rdata_nx  = rdata;
        case (state)
            IDLE: begin
                if (rdy_s && (req_a || req_b)) begin
                    grant_nx  = win_b;
                    addr_nx   = win_b ? addr_b : addr_a;
                    strobe_nx = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = STROBE;
                end
            end
            STROBE: begin
                if (!rdy_s) begin
                    strobe_nx = 1'b0;
                    state_nx  = WAIT_DONE;
                end else if (cnt >= CNT_MAX) begin
                    strobe_nx = 1'b0;
                    err_nx    = 1'b1;
                    ack_a_nx  = !grant_b;
                    ack_b_nx  = grant_b;
                    state_nx  = RESPOND;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (rdy_s) begin
                    rdata_nx = eep_data;
                    err_nx   = 1'b0;
                    ack_a_nx = !grant_b;
                    ack_b_nx = grant_b;
                    state_nx = RESPOND;
                end
            end
            RESPOND: begin
                // ack is registered on entry, so it is high for exactly this one cycle
                last_nx  = grant_b;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb/tb_eeprom_arbiter.sv - scoreboard bench for eeprom_arbiter with a behavioural reader model
module tb_eeprom_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [10:0] addr_a = '0, addr_b = '0;
    logic        ack_a, ack_b, err;
    logic [7:0]  rdata;
    logic        eep_strobe;
    logic [10:0] eep_address;
    logic        eep_ready = 1'b1;
    logic [7:0]  eep_data = '0;

    eeprom_arbiter #(.STROBE_TIMEOUT(255)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .addr_a(addr_a), .req_b(req_b), .addr_b(addr_b),
        .ack_a(ack_a), .ack_b(ack_b), .err(err), .rdata(rdata),
        .eep_strobe(eep_strobe), .eep_address(eep_address),
        .eep_ready(eep_ready), .eep_data(eep_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_b;
        logic [10:0] addr;
        logic [7:0]  data;
        logic        err;
    } exp_t;

    typedef struct {
        logic        ra;
        logic [10:0] aa;
        logic        rb;
        logic [10:0] ab;
        logic        first_b;
    } vec_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  exp_rdata = '0;
    int          mode = 0;
    int          m_cnt = 0;
    bit          hold_a = 1'b0;
    bit          prev_strobe = 1'b0;
    bit          addr_moved = 1'b0;
    logic [10:0] cap_addr = '0;
    int          run = 0;
    int          last_run = 0;

    function automatic logic [7:0] mem(input logic [10:0] a);
        if (a == 11'h123) return 8'h5A;
        return a[7:0] ^ {5'b0, a[10:8]} ^ 8'hC3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired, got no event expected one", name);
    endtask

    task automatic push_exp(input logic is_b, input logic [10:0] a, input logic e);
        exp_t x;
        x.is_b = is_b;
        x.addr = a;
        x.err  = e;
        x.data = e ? exp_rdata : mem(a);
        if (!e) exp_rdata = x.data;
        sb.push_back(x);
    endtask

    task automatic wait_empty(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (k == bound) begin
            note_fail("scoreboard_drain");
            sb.delete();
        end
    endtask

    // Reader: idle high; on strobe goes busy, drops ready, then presents data and rises
    always @(negedge clk) begin
        case (mode)
            0: begin
                if (m_cnt == 0) begin
                    eep_ready = 1'b1;
                    if (eep_strobe) m_cnt = 1;
                end else begin
                    m_cnt++;
                    if (m_cnt == 3) eep_ready = 1'b0;
                    if (m_cnt == 7) begin
                        eep_data  = mem(eep_address);
                        eep_ready = 1'b1;
                        m_cnt     = 0;
                    end
                end
            end
            1: begin eep_ready = 1'b1; m_cnt = 0; end
            default: begin eep_ready = 1'b0; m_cnt = 0; end
        endcase
    end

    // Requesters release their request right after seeing ack
    always @(negedge clk) begin
        if (ack_a && !hold_a) req_a = 1'b0;
        if (ack_b) req_b = 1'b0;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (ack_a && ack_b) check("ack_exclusive", {ack_a, ack_b}, 2'b01);
            if (eep_strobe && !prev_strobe) begin
                cap_addr   = eep_address;
                addr_moved = 1'b0;
                run        = 0;
            end else if (eep_address != cap_addr) begin
                addr_moved = 1'b1;
            end
            if (eep_strobe) run++;
            if (!eep_strobe && prev_strobe) last_run = run;
            if (ack_a || ack_b) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {ack_a, ack_b}, 2'b00);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_who", {ack_a, ack_b}, e.is_b ? 2'b01 : 2'b10);
                    check("rdata", rdata, e.data);
                    check("err", err, e.err);
                    check("eep_address", cap_addr, e.addr);
                    check("addr_stable", addr_moved, 1'b0);
                end
            end
            prev_strobe = eep_strobe;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    vec_t vecs[7];

    initial begin
        bit any_strobe;
        bit seen;
        int k;
        vecs[0] = '{1'b1, 11'h010, 1'b1, 11'h020, 1'b0};
        vecs[1] = '{1'b1, 11'h030, 1'b1, 11'h040, 1'b0};
        vecs[2] = '{1'b1, 11'h123, 1'b0, 11'h000, 1'b0};
        vecs[3] = '{1'b0, 11'h000, 1'b1, 11'h7FF, 1'b1};
        vecs[4] = '{1'b1, 11'h555, 1'b1, 11'h2AA, 1'b0};
        vecs[5] = '{1'b1, 11'h000, 1'b0, 11'h000, 1'b0};
        vecs[6] = '{1'b1, 11'h001, 1'b1, 11'h400, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {ack_a, ack_b, err, eep_strobe, rdata, eep_address}, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (vecs[i].ra && vecs[i].rb) begin
                if (vecs[i].first_b) begin
                    push_exp(1'b1, vecs[i].ab, 1'b0);
                    push_exp(1'b0, vecs[i].aa, 1'b0);
                end else begin
                    push_exp(1'b0, vecs[i].aa, 1'b0);
                    push_exp(1'b1, vecs[i].ab, 1'b0);
                end
            end else if (vecs[i].ra) begin
                push_exp(1'b0, vecs[i].aa, 1'b0);
            end else begin
                push_exp(1'b1, vecs[i].ab, 1'b0);
            end
            addr_a = vecs[i].aa;
            addr_b = vecs[i].ab;
            req_a  = vecs[i].ra;
            req_b  = vecs[i].rb;
            wait_empty(3000);
            repeat (4) @(negedge clk);
        end

        // Reader never answers: strobe times out, ack_b with err, rdata keeps old value
        mode = 1;
        repeat (4) @(negedge clk);
        push_exp(1'b1, 11'h333, 1'b1);
        addr_b = 11'h333;
        req_b  = 1'b1;
        wait_empty(1000);
        check("strobe_timeout_len", (last_run >= 255 && last_run <= 257), 1'b1);
        mode = 0;
        repeat (6) @(negedge clk);

        // Reader busy at request time: no strobe until it is ready
        mode = 2;
        repeat (4) @(negedge clk);
        push_exp(1'b0, 11'h0AA, 1'b0);
        addr_a = 11'h0AA;
        req_a  = 1'b1;
        any_strobe = 1'b0;
        repeat (12) begin
            @(negedge clk);
            any_strobe |= eep_strobe;
        end
        check("busy_no_strobe", any_strobe, 1'b0);
        mode = 0;
        wait_empty(1000);
        repeat (4) @(negedge clk);

        // A keeps re-requesting; B must still get a turn within two grants
        push_exp(1'b1, 11'h200, 1'b0);
        push_exp(1'b0, 11'h100, 1'b0);
        push_exp(1'b0, 11'h100, 1'b0);
        hold_a = 1'b1;
        addr_a = 11'h100;
        addr_b = 11'h200;
        req_a  = 1'b1;
        req_b  = 1'b1;
        for (k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (sb.size() <= 1) break;
        end
        if (k == 1000) note_fail("starvation_progress");
        hold_a = 1'b0;
        wait_empty(1000);
        repeat (4) @(negedge clk);

        // Reset while waiting for the reader: no ack, clean outputs, request completes afterwards
        addr_a = 11'h123;
        req_a  = 1'b1;
        seen   = 1'b0;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (eep_strobe) seen = 1'b1;
            else if (seen) break;
        end
        if (k == 200) note_fail("strobe_fall");
        reset_n = 1'b0;
        #1;
        check("midreset_outputs", {ack_a, ack_b, err, eep_strobe, rdata, eep_address}, 0);
        repeat (3) @(negedge clk);
        check("midreset_hold", {ack_a, ack_b, err, eep_strobe, rdata, eep_address}, 0);
        reset_n = 1'b1;
        exp_rdata = 8'h00;
        push_exp(1'b0, 11'h123, 1'b0);
        wait_empty(1000);
        check("req_a_released", req_a, 1'b0);
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
